vga_pattern_gen: RTL and testbench

//   Pixel source upstream of the VGA timing/DAC controller. Returns one registered 24-bit RGB pixel
//   per active-area coordinate the controller requests. Four selectable test patterns, one animated
//   (bouncing box). Mode changes are applied only at frame boundaries, so no frame shows a torn image.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_pattern_gen_if.sv | 27 ++
 rtl/vga_box_mover.sv | 56 +++++
 rtl/vga_pattern_gen.sv | 106 ++++++++++
 tb/tb_vga_pattern_gen.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared encodings and colour constants for the VGA test-pattern generator.
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_SOLID = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_BOX   = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_e;

   localparam logic [23:0] WHITE     = 24'hffffff;
   localparam logic [23:0] YELLOW    = 24'hffff00;
   localparam logic [23:0] CYAN      = 24'h00ffff;
   localparam logic [23:0] GREEN     = 24'h00ff00;
   localparam logic [23:0] MAGENTA   = 24'hff00ff;
   localparam logic [23:0] RED       = 24'hff0000;
   localparam logic [23:0] BLUE      = 24'h0000ff;
   localparam logic [23:0] BLACK     = 24'h000000;
   localparam logic [23:0] BG_BLUE   = 24'h00003f;
   localparam logic [23:0] BOX_GREEN = 24'h003f00;

   function automatic logic [23:0] bar_colour(input logic [2:0] bar);
      logic [23:0] c;
      unique case (bar)
         3'd0:    c = WHITE;
         3'd1:    c = YELLOW;
         3'd2:    c = CYAN;
         3'd3:    c = GREEN;
         3'd4:    c = MAGENTA;
         3'd5:    c = RED;
         3'd6:    c = BLUE;
         default: c = BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel request/response bundle between the timing controller and the pattern generator.
interface vga_pattern_gen_if;
   import vga_pkg::*;

   logic        frame_start;
   logic        pix_req;
   logic [11:0] pix_x;
   logic [11:0] pix_y;
   logic [1:0]  mode_sel;
   logic        pix_valid;
   logic [7:0]  pix_r;
   logic [7:0]  pix_g;
   logic [7:0]  pix_b;
   logic [1:0]  mode_act;
   logic [15:0] frame_cnt;

   modport master (
      output frame_start, pix_req, pix_x, pix_y, mode_sel,
      input  pix_valid, pix_r, pix_g, pix_b, mode_act, frame_cnt
   );

   modport slave (
      input  frame_start, pix_req, pix_x, pix_y, mode_sel,
      output pix_valid, pix_r, pix_g, pix_b, mode_act, frame_cnt
   );

endinterface

// File: rtl/vga_box_mover.sv
// One axis of the bouncing box: steps once per frame and reflects at either edge.
module vga_box_mover
   import vga_pkg::*;
#(
   parameter int unsigned LIMIT = 640,
   parameter int unsigned SIZE  = 64,
   parameter int unsigned STEP  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        step_en,
   output logic [11:0] pos
);

   localparam logic [12:0] LIMIT_W = 13'(LIMIT);
   localparam logic [12:0] SIZE_W  = 13'(SIZE);
   localparam logic [12:0] STEP_W  = 13'(STEP);
   localparam logic [12:0] HOME_W  = 13'(LIMIT - SIZE);

   dir_e        r_dir;
   logic [11:0] r_pos;
   logic [12:0] w_pos13;

   // 13-bit arithmetic keeps pos+STEP+SIZE from wrapping near the far edge
   assign w_pos13 = {1'b0, r_pos};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_dir <= DIR_POS;
         r_pos <= '0;
      end else if (step_en) begin
         case (r_dir)
            DIR_POS: begin
               if (w_pos13 + STEP_W + SIZE_W >= LIMIT_W) begin
                  r_pos <= HOME_W[11:0];
                  r_dir <= DIR_NEG;
               end else begin
                  r_pos <= r_pos + STEP_W[11:0];
               end
            end
            DIR_NEG: begin
               if (w_pos13 <= STEP_W) begin
                  r_pos <= '0;
                  r_dir <= DIR_POS;
               end else begin
                  r_pos <= r_pos - STEP_W[11:0];
               end
            end
            default: r_dir <= DIR_POS;
         endcase
      end
   end

   assign pos = r_pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: frame-synchronous mode latch, pattern mux and 1-cycle output register.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACT     = 640,
   parameter int unsigned V_ACT     = 480,
   parameter int unsigned BOX_SIZE  = 64,
   parameter int unsigned STEP      = 4,
   parameter int unsigned CELL_LOG2 = 5
) (
   input logic               clk,
   input logic               rst_n,
   vga_pattern_gen_if.slave  pix_if
);

   localparam int unsigned BAR_W = H_ACT / 8;

   mode_e       r_mode;
   logic [15:0] r_frame_cnt;
   logic        r_valid;
   logic [23:0] r_rgb;

   logic [11:0] w_bx;
   logic [11:0] w_by;
   logic [12:0] w_x13;
   logic [12:0] w_y13;
   logic        w_in_range;
   logic        w_in_box;
   logic        w_check;
   logic [2:0]  w_bar;
   logic [23:0] w_rgb;

   vga_box_mover #(
      .LIMIT (H_ACT),
      .SIZE  (BOX_SIZE),
      .STEP  (STEP)
   ) u_box_x (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_en (pix_if.frame_start),
      .pos     (w_bx)
   );

   vga_box_mover #(
      .LIMIT (V_ACT),
      .SIZE  (BOX_SIZE),
      .STEP  (STEP)
   ) u_box_y (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_en (pix_if.frame_start),
      .pos     (w_by)
   );

   assign w_x13      = {1'b0, pix_if.pix_x};
   assign w_y13      = {1'b0, pix_if.pix_y};
   assign w_in_range = (w_x13 < 13'(H_ACT)) && (w_y13 < 13'(V_ACT));
   assign w_check    = pix_if.pix_x[CELL_LOG2] ^ pix_if.pix_y[CELL_LOG2];
   assign w_in_box   = (w_x13 >= {1'b0, w_bx}) && (w_x13 < {1'b0, w_bx} + 13'(BOX_SIZE)) &&
                       (w_y13 >= {1'b0, w_by}) && (w_y13 < {1'b0, w_by} + 13'(BOX_SIZE));

   // Bar index by counting crossed thresholds, avoiding a divider
   always_comb begin
      w_bar = '0;
      for (int k = 1; k < 8; k++) begin
         if (w_x13 >= 13'(k * BAR_W)) w_bar = 3'(k);
      end
   end

   always_comb begin
      w_rgb = BLACK;
      if (pix_if.pix_req && w_in_range) begin
         unique case (r_mode)
            MODE_SOLID: w_rgb = BG_BLUE;
            MODE_BARS:  w_rgb = bar_colour(w_bar);
            MODE_CHECK: w_rgb = w_check ? WHITE : BLACK;
            MODE_BOX:   w_rgb = w_in_box ? BOX_GREEN : BG_BLUE;
            default:    w_rgb = BLACK;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mode      <= MODE_SOLID;
         r_frame_cnt <= '0;
         r_valid     <= 1'b0;
         r_rgb       <= '0;
      end else begin
         r_valid <= pix_if.pix_req;
         r_rgb   <= w_rgb;
         if (pix_if.frame_start) begin
            r_mode      <= mode_e'(pix_if.mode_sel);
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign pix_if.pix_valid = r_valid;
   assign pix_if.pix_r     = r_rgb[23:16];
   assign pix_if.pix_g     = r_rgb[15:8];
   assign pix_if.pix_b     = r_rgb[7:0];
   assign pix_if.mode_act  = r_mode;
   assign pix_if.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized bench for vga_pattern_gen against an arithmetic model of the patterns and box path.
module tb_vga_pattern_gen;

   localparam int H = 640;
   localparam int V = 480;
   localparam int BOX = 64;
   localparam int STP = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vga_pattern_gen_if u_if ();

   vga_pattern_gen u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pix_if (u_if)
   );

   int          n_total = 0;
   int          n_bad = 0;
   logic [1:0]  m_mode;
   int          m_frames;
   logic [23:0] bar_tab [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Box position after n frames: triangle wave between 0 and limit-BOX
   function automatic int tri_pos(input int n, input int limit);
      int half = (limit - BOX) / STP;
      int k = n % (2 * half);
      return (k <= half) ? k * STP : (2 * half - k) * STP;
   endfunction

   function automatic logic [23:0] exp_pixel(input logic [1:0] mode, input int x, input int y,
                                             input int n);
      int bx, by;
      if (x >= H || y >= V) return 24'h0;
      case (mode)
         2'd0: return 24'h00003f;
         2'd1: return bar_tab[x / (H / 8)];
         2'd2: return (((x / 32) + (y / 32)) % 2 == 1) ? 24'hffffff : 24'h000000;
         default: begin
            bx = tri_pos(n, H);
            by = tri_pos(n, V);
            return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 24'h003f00 : 24'h00003f;
         end
      endcase
   endfunction

   function automatic logic [23:0] rgb();
      return {u_if.pix_r, u_if.pix_g, u_if.pix_b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cycle(input logic req, input int x, input int y, input logic fs,
                           input logic [1:0] msel, input string tag);
      logic [23:0] exp;
      u_if.pix_req     = req;
      u_if.pix_x       = 12'(x);
      u_if.pix_y       = 12'(y);
      u_if.frame_start = fs;
      u_if.mode_sel    = msel;
      tick();
      u_if.frame_start = 1'b0;
      exp = req ? exp_pixel(m_mode, x, y, m_frames) : 24'h0;
      if (fs) begin
         m_mode = msel;
         m_frames++;
      end
      check_eq({tag, ".valid"}, 32'(u_if.pix_valid), 32'(req));
      check_eq({tag, ".rgb"}, 32'(rgb()), 32'(exp));
      check_eq({tag, ".mode"}, 32'(u_if.mode_act), 32'(m_mode));
      check_eq({tag, ".fcnt"}, 32'(u_if.frame_cnt), 32'(m_frames & 16'hffff));
   endtask

   task automatic do_reset(input int cycles, input string tag);
      rst_n            = 1'b0;
      u_if.pix_req     = 1'b1;
      u_if.pix_x       = 12'd5;
      u_if.pix_y       = 12'd5;
      u_if.frame_start = 1'b0;
      repeat (cycles) tick();
      check_eq({tag, ".valid"}, 32'(u_if.pix_valid), 32'd0);
      check_eq({tag, ".rgb"}, 32'(rgb()), 32'd0);
      check_eq({tag, ".mode"}, 32'(u_if.mode_act), 32'd0);
      check_eq({tag, ".fcnt"}, 32'(u_if.frame_cnt), 32'd0);
      rst_n    = 1'b1;
      m_mode   = 2'd0;
      m_frames = 0;
   endtask

   task automatic rand_frame(input logic [1:0] msel);
      int n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++)
         do_cycle(1'($urandom), $urandom_range(0, 703), $urandom_range(0, 511), 1'b0,
                  2'($urandom), "rnd");
      do_cycle(1'($urandom), $urandom_range(0, 703), $urandom_range(0, 511), 1'b1, msel, "rfs");
   endtask

   initial begin
      u_if.pix_req     = 1'b0;
      u_if.pix_x       = '0;
      u_if.pix_y       = '0;
      u_if.frame_start = 1'b0;
      u_if.mode_sel    = '0;

      do_reset(3, "reset");
      do_cycle(1'b0, 0, 0, 1'b0, 2'd0, "rel0");
      do_cycle(1'b1, 0, 0, 1'b0, 2'd0, "rel1");
      check_eq("rel1.solid", 32'(rgb()), 32'h00003f);

      // Mode request mid-frame stays pending until frame_start
      do_cycle(1'b1, 10, 10, 1'b0, 2'd1, "pend0");
      do_cycle(1'b1, 200, 20, 1'b0, 2'd1, "pend1");
      check_eq("pend.solid", 32'(rgb()), 32'h00003f);
      do_cycle(1'b0, 0, 0, 1'b1, 2'd1, "fs_bars");
      do_cycle(1'b1, 0, 3, 1'b0, 2'd1, "bar_x0");
      check_eq("bar_x0.white", 32'(rgb()), 32'hffffff);
      do_cycle(1'b1, 80, 3, 1'b0, 2'd1, "bar_x80");
      check_eq("bar_x80.yellow", 32'(rgb()), 32'hffff00);
      do_cycle(1'b1, 639, 3, 1'b0, 2'd1, "bar_x639");
      check_eq("bar_x639.black", 32'(rgb()), 32'h000000);

      do_cycle(1'b0, 0, 0, 1'b1, 2'd2, "fs_chk");
      do_cycle(1'b1, 0, 0, 1'b0, 2'd2, "chk00");
      do_cycle(1'b1, 32, 0, 1'b0, 2'd2, "chk320");
      do_cycle(1'b1, 32, 32, 1'b0, 2'd2, "chk3232");
      do_cycle(1'b1, 700, 10, 1'b0, 2'd2, "chk_oob");
      check_eq("chk_oob.valid", 32'(u_if.pix_valid), 32'd1);

      // Pixel in the frame_start cycle still uses the old mode
      do_cycle(1'b0, 0, 0, 1'b1, 2'd0, "fs_solid");
      do_cycle(1'b1, 0, 0, 1'b1, 2'd3, "simul");
      check_eq("simul.old_mode", 32'(rgb()), 32'h00003f);
      do_cycle(1'b1, 0, 0, 1'b0, 2'd3, "simul_next");

      while (m_frames < 143) begin
         rand_frame(2'd3);
         if (m_frames == 104) begin
            do_cycle(1'b1, 416, 416, 1'b0, 2'd3, "y104in");
            check_eq("y104in.green", 32'(rgb()), 32'h003f00);
            do_cycle(1'b1, 416, 415, 1'b0, 2'd3, "y104out");
            check_eq("y104out.blue", 32'(rgb()), 32'h00003f);
         end
      end
      do_cycle(1'b0, 0, 0, 1'b1, 2'd3, "fs144");
      do_cycle(1'b1, 576, 256, 1'b0, 2'd3, "x144in");
      check_eq("x144in.green", 32'(rgb()), 32'h003f00);
      do_cycle(1'b1, 575, 256, 1'b0, 2'd3, "x144out");
      check_eq("x144out.blue", 32'(rgb()), 32'h00003f);
      do_cycle(1'b0, 0, 0, 1'b1, 2'd3, "fs145");
      do_cycle(1'b1, 572, 252, 1'b0, 2'd3, "x145in");
      check_eq("x145in.green", 32'(rgb()), 32'h003f00);
      do_cycle(1'b1, 636, 252, 1'b0, 2'd3, "x145out");
      check_eq("x145out.blue", 32'(rgb()), 32'h00003f);
      for (int i = 0; i < 150; i++) rand_frame(2'($urandom));

      // Restart mid-frame 50
      do_reset(2, "reset2");
      for (int i = 0; i < 50; i++) rand_frame(2'd3);
      do_cycle(1'b1, 100, 100, 1'b0, 2'd3, "f50pix");
      do_reset(1, "midreset");
      do_cycle(1'b0, 0, 0, 1'b0, 2'd3, "mr_nostale");
      do_cycle(1'b1, 0, 0, 1'b0, 2'd3, "mr_solid");
      check_eq("mr_solid.rgb", 32'(rgb()), 32'h00003f);
      do_cycle(1'b0, 0, 0, 1'b1, 2'd3, "mr_fs");
      do_cycle(1'b1, 0, 0, 1'b0, 2'd3, "mr_box00");
      do_cycle(1'b1, 4, 4, 1'b0, 2'd3, "mr_box44");

      // Frame counter wrap
      u_if.pix_req = 1'b0;
      while (m_frames < 65535) begin
         u_if.frame_start = 1'b1;
         tick();
         m_frames++;
      end
      u_if.frame_start = 1'b0;
      check_eq("wrap.ffff", 32'(u_if.frame_cnt), 32'h0000ffff);
      do_cycle(1'b1, 300, 200, 1'b1, 2'd3, "wrap0");
      for (int i = 0; i < 10; i++)
         do_cycle(1'b1, $urandom_range(0, 639), $urandom_range(0, 479), 1'b0, 2'd3, "post");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
